// File: rtl/regfile_pkg.sv
// Shared definitions for the 32x32 register file and its debug dump reader.
package regfile_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } reader_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Walks a register range through one register file read port and streams each
// word out over valid/ready; one word per 2 cycles peak, holds outputs under backpressure.
module regfile_dump_reader #(
  parameter int DATA_WIDTH = regfile_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = regfile_pkg::ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] first_reg,
  input  logic [ADDR_WIDTH-1:0] last_reg,
  output logic [ADDR_WIDTH-1:0] rf_addr,
  input  logic [DATA_WIDTH-1:0] rf_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  import regfile_pkg::*;

  reader_state_t         state;
  logic [ADDR_WIDTH-1:0] end_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      rf_addr   <= '0;
      end_reg   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rf_addr <= first_reg;
            end_reg <= last_reg;
            busy    <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          // rf_data is combinational from rf_addr, so this captures the
          // register contents as seen during this cycle.
          out_data  <= rf_data;
          out_addr  <= rf_addr;
          out_last  <= (rf_addr == end_reg);
          out_valid <= 1'b1;
          state     <= SEND;
        end
        SEND: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              // Wraps 31 -> 0 so ranges with first > last scan across r0.
              rf_addr <= rf_addr + ADDR_WIDTH'(1);
              state   <= READ;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench: behavioural register file plus queue-based reference of expected dump words.
module tb_regfile_dump_reader;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [4:0]  first_reg, last_reg, rf_addr, out_addr;
  logic [31:0] rf_data, out_data;
  logic        out_valid, out_ready, out_last, busy, done;

  logic [31:0] regs [32];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        l;
  } word_t;
  word_t exp_q[$];

  regfile_dump_reader dut (
    .clock(clock), .reset(reset), .start(start),
    .first_reg(first_reg), .last_reg(last_reg),
    .rf_addr(rf_addr), .rf_data(rf_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_addr(out_addr), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // Register file read port: r0 is hard-wired to zero.
  assign rf_data = (rf_addr == 5'd0) ? 32'h0 : regs[rf_addr];

  always @(posedge clock) if (!reset && done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // mode 0: ready high, 1: random ready, 2: stall first word 5 cycles
  task automatic run_scan(input logic [4:0] f, input logic [4:0] l, input int mode, input bit inject);
    int n, cyc, stall, popped, budget, d0;
    bit hs, fin, injected;
    logic [4:0] a;
    n = (((int'(l) - int'(f)) % 32) + 32) % 32 + 1;
    exp_q.delete();
    for (int i = 0; i < n; i++) begin
      a = 5'((int'(f) + i) % 32);
      exp_q.push_back('{a, (a == 5'd0) ? 32'h0 : regs[a], (i == n - 1)});
    end
    d0 = done_cnt;
    start = 1'b1; first_reg = f; last_reg = l; out_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    check("start_busy", 64'(busy), 64'd1);
    check("start_rf_addr", 64'(rf_addr), 64'(f));
    check("start_valid_low", 64'(out_valid), 64'd0);
    cyc = 0; stall = 0; popped = 0; budget = 0; fin = 0; injected = 0;
    while (!fin && budget < 400) begin
      hs = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 64'd1, 64'd0);
        end else begin
          check("out_data", 64'(out_data), 64'(exp_q[0].d));
          check("out_addr", 64'(out_addr), 64'(exp_q[0].a));
          check("out_last", 64'(out_last), 64'(exp_q[0].l));
          check("rf_addr_hold", 64'(rf_addr), 64'(exp_q[0].a));
          case (mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'($urandom_range(0, 1));
            default: begin
              if (popped == 0 && stall < 5) begin
                out_ready = 1'b0;
                stall++;
              end else begin
                out_ready = 1'b1;
              end
            end
          endcase
          hs = out_ready;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      check("busy_during_scan", 64'(busy), 64'd1);
      check("done_during_scan", 64'(done), 64'd0);
      if (inject && popped == 1 && !injected) begin
        start = 1'b1; first_reg = ~f; last_reg = ~l; injected = 1;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      cyc++; budget++;
      if (hs) begin
        popped++;
        if (exp_q[0].l) fin = 1;
        void'(exp_q.pop_front());
      end
      @(negedge clock);
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (!fin) begin
      check("scan_timeout", 64'd0, 64'd1);
    end else begin
      check("done_pulse", 64'(done), 64'd1);
      check("busy_after_done", 64'(busy), 64'd0);
      check("valid_after_done", 64'(out_valid), 64'd0);
      check("word_count", 64'(popped), 64'(n));
      if (mode == 0) check("scan_cycles", 64'(cyc), 64'(2 * n));
      @(negedge clock);
      check("done_one_cycle", 64'(done), 64'd0);
      check("done_count", 64'(done_cnt - d0), 64'd1);
    end
  endtask

  task automatic reset_mid_scan();
    int budget;
    start = 1'b1; first_reg = 5'd5; last_reg = 5'd9; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    budget = 0;
    while (!out_valid && budget < 20) begin
      @(negedge clock);
      budget++;
    end
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data", 64'(out_data), 64'd0);
    check("rst_addr", 64'(out_addr), 64'd0);
    check("rst_last", 64'(out_last), 64'd0);
    check("rst_rf_addr", 64'(rf_addr), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; first_reg = '0; last_reg = '0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    check("reset_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_rf_addr", 64'(rf_addr), 64'd0);
    check("reset_out_data", 64'(out_data), 64'd0);
    check("reset_out_addr", 64'(out_addr), 64'd0);
    check("reset_out_last", 64'(out_last), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    regs[1] = 32'hAAAA_AAAA; regs[2] = 32'h5555_5555;
    run_scan(5'd1, 5'd2, 0, 0);

    regs[30] = 32'h1E; regs[31] = 32'h1F; regs[1] = 32'h01; regs[0] = 32'hBAD0_0000;
    run_scan(5'd30, 5'd1, 0, 0);

    regs[7] = 32'hDEAD_BEEF;
    run_scan(5'd7, 5'd7, 0, 0);

    run_scan(5'd4, 5'd9, 2, 0);
    run_scan(5'd10, 5'd14, 1, 1);
    run_scan(5'd0, 5'd31, 0, 0);

    regs[3] = 32'h3333_C0DE;
    reset_mid_scan();
    run_scan(5'd3, 5'd3, 0, 0);

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 4; k++) regs[$urandom_range(0, 31)] = $urandom;
      run_scan(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential debug reader for the 32×32 register file. On a start pulse it walks a programmable register range through one of the register file's read ports (rs/output_data_A), captures each word and streams it out over a valid/ready handshake tagged with its register number. It sits beside the CPU datapath and feeds debug/trace logic. It is the reader counterpart to the register file's write side.

## Interface
Parameters:
- DATA_WIDTH, 32, register word width
- ADDR_WIDTH, 5, register index width (32 registers)

Ports:
- clock  in  1  single system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a scan; ignored while busy
- first_reg  in  ADDR_WIDTH  first register of range, sampled with start
- last_reg  in  ADDR_WIDTH  last register of range, sampled with start
- rf_addr  out  ADDR_WIDTH  drives register file read address (rs)
- rf_data  in  DATA_WIDTH  register file read data (output_data_A), combinational from rf_addr
- out_valid  out  1  out_data/out_addr/out_last hold a word
- out_ready  in  1  consumer accepts word when out_valid && out_ready
- out_data  out  DATA_WIDTH  captured register value
- out_addr  out  ADDR_WIDTH  register index of out_data
- out_last  out  1  current word is the final word of the scan
- busy  out  1  scan in progress (state != IDLE)
- done  out  1  one-cycle pulse after final word is accepted

## Operation
- FSM states: IDLE, READ, SEND.
- IDLE: on start, latch first_reg into rf_addr and last_reg into internal end register; go to READ.
- READ: register rf_data into out_data, rf_addr into out_addr; set out_valid; set out_last if rf_addr == end; go to SEND.
- SEND: hold all out_* stable while out_valid && !out_ready. On handshake: if out_last, clear out_valid, pulse done, go to IDLE; otherwise clear out_valid, rf_addr <= rf_addr + 1 (mod 32), go to READ.
- Range: word count = (last_reg − first_reg) mod 32, plus 1. first_reg == last_reg yields exactly one word. first_reg > last_reg wraps 31 → 0, e.g. 30..1 yields r30, r31, r0, r1.
- r0 is read like any other register; the value reported is whatever the register file returns (0).
- Concurrent writes: the captured value is rf_data in the READ cycle. A write to the same register at the closing edge of that cycle is not reflected. A write completed before the READ cycle is reflected.
- start during READ/SEND is ignored; first_reg/last_reg are not resampled.

## Timing
- Reset values: rf_addr = 0, out_valid = 0, out_data = 0, out_addr = 0, out_last = 0, busy = 0, done = 0; state = IDLE.
- Reset mid-scan: the next edge returns the block to IDLE with all outputs at reset values. Any word pending in SEND is dropped.
- start sampled at edge N → rf_addr = first_reg and busy = 1 after edge N; out_valid = 1 after edge N+1.
- Handshake at edge M on a non-last word → out_valid = 0 after M, next word valid after M+1. Peak throughput is one word per 2 cycles.
- Final handshake at edge M → done = 1 and busy = 0 for the cycle after M only. A start in that cycle is accepted.
- out_ready is ignored when out_valid = 0.
- Full 0..31 scan with out_ready tied high takes 64 cycles from start edge to done.

## Structure
- Shared package regfile_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REGS = 32
  - reader state enum (IDLE, READ, SEND)
  - the register file also imports DATA_WIDTH and ADDR_WIDTH from it.
- No sub-module: the FSM, address counter and output register live in one module. The register file is instantiated only in the bench.

## Test plan
- Reset, then write r1 = AAAA_AAAA and r2 = 5555_5555. Scan 1..2 with out_ready = 1 → words (1, AAAA_AAAA, last = 0), then (2, 5555_5555, last = 1); done pulses once; busy low afterwards.
- Scan 30..1 with r30 = 1E, r31 = 1F, r1 = 01 → out_addr sequence 30, 31, 0, 1; r0 word = 0; out_last only on r1.
- Single-register scan 7..7 with r7 = DEAD_BEEF → exactly one word, out_last = 1, done one cycle after handshake.
- Backpressure: out_ready low for 5 cycles on the first word → out_data/out_addr/out_last stable and rf_addr unchanged; the scan then completes normally.
- start pulsed mid-scan with different first_reg/last_reg → ignored; original sequence completes.
- Assert reset while in SEND with out_valid = 1 → after the next edge all outputs are 0 and state is IDLE. A new scan 3..3 then returns the r3 value.
